// File: rtl/skin_blob_tracker_pkg.sv
// Shared vision definitions: tracker FSM encoding and port-width helpers.
package skin_blob_tracker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StReport
    } tracker_state_e;

    function automatic int unsigned x_width(input int unsigned h_res);
        return $clog2(h_res);
    endfunction

    function automatic int unsigned y_width(input int unsigned v_res);
        return $clog2(v_res);
    endfunction

    function automatic int unsigned count_width(input int unsigned h_res, input int unsigned v_res);
        return $clog2(h_res * v_res + 1);
    endfunction

endpackage

// File: rtl/skin_blob_tracker_raster_counter.sv
// Raster position tracker: holds the coordinate of the next expected pixel and flags the last one.
module raster_counter
    import skin_blob_tracker_pkg::*;
#(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240,
    localparam int unsigned XW = x_width(H_RES),
    localparam int unsigned YW = y_width(V_RES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          adv_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_wrap;

    assign x_wrap = (x_q == XW'(H_RES - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        // The start pixel itself is (0,0), so the next one is (1,0).
        if (start_i) begin
            x_d = XW'(1);
            y_d = '0;
        end else if (adv_i) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = (y_q == YW'(V_RES - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_wrap && (y_q == YW'(V_RES - 1));

endmodule

// File: rtl/skin_blob_tracker.sv
// Per-frame skin-pixel bounding box and count, reported one cycle after the last pixel.
module skin_blob_tracker
    import skin_blob_tracker_pkg::*;
#(
    parameter int unsigned H_RES     = 320,
    parameter int unsigned V_RES     = 240,
    parameter int unsigned MIN_COUNT = 64,
    localparam int unsigned XW = x_width(H_RES),
    localparam int unsigned YW = y_width(V_RES),
    localparam int unsigned CW = count_width(H_RES, V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic          sof,
    input  logic          skin_pix,
    output logic          box_valid,
    output logic          box_found,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic [CW-1:0] skin_count
);

    tracker_state_e state_q, state_d;

    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic [XW-1:0] run_xmin_q, run_xmin_d, run_xmax_q, run_xmax_d;
    logic [YW-1:0] run_ymin_q, run_ymin_d, run_ymax_q, run_ymax_d;

    logic          box_valid_q, box_valid_d, box_found_q, box_found_d;
    logic [XW-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
    logic [YW-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
    logic [CW-1:0] skin_count_q, skin_count_d;

    logic          start, adv, rc_last;
    logic [XW-1:0] rc_x, px;
    logic [YW-1:0] rc_y, py;

    // REPORT ignores everything, including a sof.
    assign start = pix_valid && sof && (state_q != StReport);
    assign adv   = pix_valid && !sof && (state_q == StAccum);
    assign px    = start ? '0 : rc_x;
    assign py    = start ? '0 : rc_y;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster_counter (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (start),
        .adv_i   (adv),
        .x_o     (rc_x),
        .y_o     (rc_y),
        .last_o  (rc_last)
    );

    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        run_xmin_d   = run_xmin_q;
        run_xmax_d   = run_xmax_q;
        run_ymin_d   = run_ymin_q;
        run_ymax_d   = run_ymax_q;
        box_valid_d  = 1'b0;
        box_found_d  = box_found_q;
        x_min_d      = x_min_q;
        x_max_d      = x_max_q;
        y_min_d      = y_min_q;
        y_max_d      = y_max_q;
        skin_count_d = skin_count_q;

        if (start) begin
            state_d    = StAccum;
            run_cnt_d  = '0;
            run_xmin_d = '1;
            run_xmax_d = '0;
            run_ymin_d = '1;
            run_ymax_d = '0;
        end

        if ((start || adv) && skin_pix) begin
            run_cnt_d = run_cnt_d + CW'(1);
            if (px < run_xmin_d) run_xmin_d = px;
            if (px > run_xmax_d) run_xmax_d = px;
            if (py < run_ymin_d) run_ymin_d = py;
            if (py > run_ymax_d) run_ymax_d = py;
        end

        if (adv && rc_last) begin
            state_d      = StReport;
            box_valid_d  = 1'b1;
            skin_count_d = run_cnt_d;
            box_found_d  = (32'(run_cnt_d) >= MIN_COUNT);
            x_min_d      = box_found_d ? run_xmin_d : '0;
            x_max_d      = box_found_d ? run_xmax_d : '0;
            y_min_d      = box_found_d ? run_ymin_d : '0;
            y_max_d      = box_found_d ? run_ymax_d : '0;
        end

        if (state_q == StReport) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            run_cnt_q    <= '0;
            run_xmin_q   <= '0;
            run_xmax_q   <= '0;
            run_ymin_q   <= '0;
            run_ymax_q   <= '0;
            box_valid_q  <= 1'b0;
            box_found_q  <= 1'b0;
            x_min_q      <= '0;
            x_max_q      <= '0;
            y_min_q      <= '0;
            y_max_q      <= '0;
            skin_count_q <= '0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            run_xmin_q   <= run_xmin_d;
            run_xmax_q   <= run_xmax_d;
            run_ymin_q   <= run_ymin_d;
            run_ymax_q   <= run_ymax_d;
            box_valid_q  <= box_valid_d;
            box_found_q  <= box_found_d;
            x_min_q      <= x_min_d;
            x_max_q      <= x_max_d;
            y_min_q      <= y_min_d;
            y_max_q      <= y_max_d;
            skin_count_q <= skin_count_d;
        end
    end

    assign box_valid  = box_valid_q;
    assign box_found  = box_found_q;
    assign x_min      = x_min_q;
    assign x_max      = x_max_q;
    assign y_min      = y_min_q;
    assign y_max      = y_max_q;
    assign skin_count = skin_count_q;

endmodule

// File: tb/tb_skin_blob_tracker.sv
// Directed bench for skin_blob_tracker on an 8x4 raster with MIN_COUNT = 2.
module tb_skin_blob_tracker;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;
    localparam int unsigned MINC = 2;

    logic       clk, rst, pix_valid, sof, skin_pix;
    logic       box_valid, box_found;
    logic [2:0] x_min, x_max;
    logic [1:0] y_min, y_max;
    logic [5:0] skin_count;

    int n_checks = 0;
    int n_fail   = 0;

    skin_blob_tracker #(
        .H_RES     (H),
        .V_RES     (V),
        .MIN_COUNT (MINC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .skin_pix   (skin_pix),
        .box_valid  (box_valid),
        .box_found  (box_found),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .skin_count (skin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_box(input string tag, input logic [31:0] found, input logic [31:0] xlo,
                             input logic [31:0] xhi, input logic [31:0] ylo,
                             input logic [31:0] yhi, input logic [31:0] cnt);
        check({tag, " box_found"}, 32'(box_found), found);
        check({tag, " x_min"}, 32'(x_min), xlo);
        check({tag, " x_max"}, 32'(x_max), xhi);
        check({tag, " y_min"}, 32'(y_min), ylo);
        check({tag, " y_max"}, 32'(y_max), yhi);
        check({tag, " skin_count"}, 32'(skin_count), cnt);
    endtask

    // One valid pixel, sampled on the next rising edge; returns 1 time unit after that edge.
    task automatic drive_pix(input logic s, input logic k);
        @(negedge clk);
        pix_valid = 1'b1;
        sof       = s;
        skin_pix  = k;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        skin_pix  = 1'b0;
    endtask

    // mask bit index = y*H + x
    task automatic send_pixels(input string tag, input logic [31:0] mask, input int n,
                               input bit with_sof, input bit gaps, input bit pulse_last);
        int early;
        int g;
        early = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    @(posedge clk);
                    #1;
                    if (box_valid) early++;
                end
            end
            drive_pix(with_sof && (i == 0), mask[i]);
            if (!(pulse_last && (i == n - 1)) && box_valid) early++;
        end
        check({tag, " unexpected box_valid"}, 32'(early), 32'd0);
    endtask

    task automatic end_report(input string tag);
        @(posedge clk);
        #1;
        check({tag, " pulse width"}, 32'(box_valid), 32'd0);
    endtask

    logic [31:0] m1, m2, m4, m6;

    initial begin
        rst       = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        skin_pix  = 1'b0;
        m1 = (32'd1 << 10) | (32'd1 << 21) | (32'd1 << 27);
        m2 = 32'd1 << 31;
        m4 = (32'd1 << 9) | (32'd1 << 22);
        m6 = (32'd1 << 0) | (32'd1 << 7);

        #12;
        check("reset box_valid", 32'(box_valid), 32'd0);
        check_box("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Three scattered skin pixels
        send_pixels("t1", m1, 32, 1, 0, 1);
        check("t1 box_valid", 32'(box_valid), 32'd1);
        check_box("t1", 1, 2, 5, 1, 3, 3);
        end_report("t1");
        check_box("t1 hold", 1, 2, 5, 1, 3, 3);

        // Below MIN_COUNT: box zeroed
        send_pixels("t2", m2, 32, 1, 0, 1);
        check("t2 box_valid", 32'(box_valid), 32'd1);
        check_box("t2", 0, 0, 0, 0, 0, 1);
        end_report("t2");

        // Full skin frame with stalls
        send_pixels("t3", 32'hFFFF_FFFF, 32, 1, 1, 1);
        check("t3 box_valid", 32'(box_valid), 32'd1);
        check_box("t3", 1, 0, 7, 0, 3, 32);
        end_report("t3");

        // Restart on sof mid-frame discards the partial frame
        send_pixels("t4 partial", 32'hFFFF_FFFF, 10, 1, 0, 0);
        send_pixels("t4", m4, 32, 1, 0, 1);
        check("t4 box_valid", 32'(box_valid), 32'd1);
        check_box("t4", 1, 1, 6, 1, 2, 2);
        end_report("t4");

        // Asynchronous reset mid-frame, then sof-less pixels are ignored
        send_pixels("t5 partial", 32'hFFFF_FFFF, 5, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("t5 async box_valid", 32'(box_valid), 32'd0);
        check_box("t5 async", 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        send_pixels("t5 no sof", 32'hFFFF_FFFF, 32, 0, 0, 0);
        check_box("t5 idle", 0, 0, 0, 0, 0, 0);
        send_pixels("t5", m1, 32, 1, 0, 1);
        check("t5 box_valid", 32'(box_valid), 32'd1);
        check_box("t5", 1, 2, 5, 1, 3, 3);

        // Back-to-back frames with a single-cycle gap (the report cycle)
        end_report("t6 f1");
        send_pixels("t6 f2", m6, 31, 1, 0, 0);
        check_box("t6 hold", 1, 2, 5, 1, 3, 3);
        drive_pix(1'b0, m6[31]);
        check("t6 f2 box_valid", 32'(box_valid), 32'd1);
        check_box("t6 f2", 1, 0, 7, 0, 0, 2);
        end_report("t6 f2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
